// File: rtl/life_sequencer_if.sv
// Engine handshake bundle between the generation sequencer (master) and the
// Game-of-Life scan engine (slave).
interface life_sequencer_if;
    logic [63:0] eng_board;
    logic        eng_start;
    logic [63:0] eng_next_state;
    logic        eng_done;

    modport master (
        output eng_board,
        output eng_start,
        input  eng_next_state,
        input  eng_done
    );

    modport slave (
        input  eng_board,
        input  eng_start,
        output eng_next_state,
        output eng_done
    );
endinterface

// File: rtl/life_sequencer.sv
// Generation sequencer: owns the 64-cell board, launches one engine pass per
// generation (free-run tick or single step) and commits the engine result.
module life_sequencer #(
    parameter int TICK_DIV       = 1000000,
    parameter int TIMEOUT        = 255,
    parameter bit HALT_ON_STABLE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [63:0]             seed_i,
    input  logic                    load_i,
    input  logic                    run_i,
    input  logic                    step_i,
    life_sequencer_if.master        eng,
    output logic [63:0]             board_o,
    output logic [15:0]             gen_count_o,
    output logic                    busy_o,
    output logic                    stable_o,
    output logic                    extinct_o,
    output logic                    timeout_err_o
);

    localparam int TW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DONE = 2'd1;
    localparam logic [1:0] ST_COMMIT    = 2'd2;

    logic [1:0]    state_q,      state_d;
    logic [63:0]   board_q,      board_d;
    logic [63:0]   result_q,     result_d;
    logic [15:0]   gen_q,        gen_d;
    logic          stable_q,     stable_d;
    logic          extinct_q,    extinct_d;
    logic          terr_q,       terr_d;
    logic          start_q,      start_d;
    logic [TW-1:0] tick_cnt_q,   tick_cnt_d;
    logic [WW-1:0] wd_q,         wd_d;

    logic tick;
    logic halt;

    assign tick = (tick_cnt_q == TICK_LAST);
    assign halt = HALT_ON_STABLE & (stable_q | extinct_q);

    // The rate counter free-runs regardless of FSM state or load.
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        result_d  = result_q;
        gen_d     = gen_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;
        terr_d    = terr_q;
        start_d   = start_q;
        wd_d      = wd_q;

        if (load_i) begin
            // Any eng_done arriving together with load is simply not looked at.
            board_d   = seed_i;
            gen_d     = '0;
            stable_d  = 1'b0;
            extinct_d = 1'b0;
            terr_d    = 1'b0;
            start_d   = 1'b0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (step_i || (run_i && tick && !halt)) begin
                        state_d = ST_WAIT_DONE;
                        start_d = 1'b1;
                        wd_d    = '0;
                    end
                end
                ST_WAIT_DONE: begin
                    // A done in the very cycle the watchdog expires still counts.
                    if (eng.eng_done) begin
                        result_d = eng.eng_next_state;
                        start_d  = 1'b0;
                        state_d  = ST_COMMIT;
                    end else if (wd_q == WD_LAST) begin
                        terr_d  = 1'b1;
                        start_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    stable_d  = (result_q == board_q);
                    extinct_d = (result_q == 64'd0);
                    board_d   = result_q;
                    gen_d     = gen_q + 16'd1;
                    state_d   = ST_IDLE;
                end
                default: begin
                    start_d = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            board_q    <= '0;
            result_q   <= '0;
            gen_q      <= '0;
            stable_q   <= 1'b0;
            extinct_q  <= 1'b0;
            terr_q     <= 1'b0;
            start_q    <= 1'b0;
            tick_cnt_q <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            result_q   <= result_d;
            gen_q      <= gen_d;
            stable_q   <= stable_d;
            extinct_q  <= extinct_d;
            terr_q     <= terr_d;
            start_q    <= start_d;
            tick_cnt_q <= tick_cnt_d;
            wd_q       <= wd_d;
        end
    end

    assign eng.eng_board  = board_q;
    assign eng.eng_start  = start_q;
    assign board_o        = board_q;
    assign gen_count_o    = gen_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign stable_o       = stable_q;
    assign extinct_o      = extinct_q;
    assign timeout_err_o  = terr_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Self-checking bench for life_sequencer: table vectors, randomized steps against
// a Game-of-Life reference, and hand-written timing/corner sequences.
module tb_life_sequencer;

    localparam logic [63:0] BLINK_A = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_B = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] seed = '0;
    logic        load = 1'b0;
    logic        run  = 1'b0;
    logic        step = 1'b0;
    logic [63:0] board;
    logic [15:0] gen_count;
    logic        busy, stable, extinct, timeout_err;

    life_sequencer_if ifc ();

    life_sequencer #(
        .TICK_DIV      (100),
        .TIMEOUT       (20),
        .HALT_ON_STABLE(1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seed_i       (seed),
        .load_i       (load),
        .run_i        (run),
        .step_i       (step),
        .eng          (ifc),
        .board_o      (board),
        .gen_count_o  (gen_count),
        .busy_o       (busy),
        .stable_o     (stable),
        .extinct_o    (extinct),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    // Bounded (non-wrapping) 8x8 Life rule.
    function automatic logic [63:0] life(input logic [63:0] b);
        logic [63:0] nb;
        nb = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8)
                            n += int'(b[(r + dr) * 8 + (c + dc)]);
                nb[r * 8 + c] = (n == 3) || (b[r * 8 + c] && n == 2);
            end
        end
        return nb;
    endfunction

    // Engine stub: mode 0 = answers after eng_lat cycles, 1 = never answers,
    // 2 = driven by hand through man_done/man_next.
    int          mode = 0;
    int          eng_lat = 3;
    int          ecnt = 0;
    logic        man_done = 1'b0;
    logic [63:0] man_next = '0;

    always @(posedge clk) begin
        if (mode != 0 || !ifc.eng_start) ecnt <= 0;
        else if (ecnt < 1000) ecnt <= ecnt + 1;
    end

    assign ifc.eng_done = (mode == 0) ? (ifc.eng_start && ecnt == eng_lat) :
                          (mode == 2) ? man_done : 1'b0;
    assign ifc.eng_next_state = (mode == 2) ? man_next : life(ifc.eng_board);

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] s);
        seed = s;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 300) begin
            cyc();
            k++;
        end
        chk("idle_wait", {63'd0, busy}, 64'd0);
    endtask

    task automatic do_step(input bit extra_step);
        step = 1'b1;
        cyc();
        step = 1'b0;
        if (extra_step) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
        end
        wait_idle();
    endtask

    typedef struct {
        logic [63:0] seed;
        int          nsteps;
        logic [63:0] exp_board;
        logic [15:0] exp_gen;
        logic        exp_stable;
        logic        exp_extinct;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{BLINK_A,             1, BLINK_B,             16'd1, 1'b0, 1'b0};
        vecs[1] = '{BLINK_A,             2, BLINK_A,             16'd2, 1'b0, 1'b0};
        vecs[2] = '{BLOCK,               1, BLOCK,               16'd1, 1'b1, 1'b0};
        vecs[3] = '{64'h1,               1, 64'h0,               16'd1, 1'b0, 1'b1};
        vecs[4] = '{64'hFF,              1, 64'h7E7E,            16'd1, 1'b0, 1'b0};
        vecs[5] = '{64'h0,               1, 64'h0,               16'd1, 1'b1, 1'b1};
        vecs[6] = '{BLOCK,               3, BLOCK,               16'd3, 1'b1, 1'b0};

        // Reset state.
        repeat (3) cyc();
        chk("rst_board", board, 64'd0);
        chk("rst_gen", {48'd0, gen_count}, 64'd0);
        chk("rst_flags", {59'd0, busy, stable, extinct, timeout_err, ifc.eng_start}, 64'd0);
        chk("rst_eng_board", ifc.eng_board, 64'd0);
        rst_n = 1'b1;
        cyc();

        // Table vectors.
        mode = 0;
        eng_lat = 3;
        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].seed);
            for (int s = 0; s < vecs[i].nsteps; s++) do_step(1'b0);
            $display("vec %0d: seed=%h steps=%0d board=%h gen=%0d", i, vecs[i].seed,
                     vecs[i].nsteps, board, gen_count);
            chk("vec_board", board, vecs[i].exp_board);
            chk("vec_gen", {48'd0, gen_count}, {48'd0, vecs[i].exp_gen});
            chk("vec_stable", {63'd0, stable}, {63'd0, vecs[i].exp_stable});
            chk("vec_extinct", {63'd0, extinct}, {63'd0, vecs[i].exp_extinct});
            chk("vec_eng_board", ifc.eng_board, vecs[i].exp_board);
        end

        // Exact step latency with a 6-cycle engine.
        eng_lat = 6;
        do_load(BLINK_A);
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("lat_start_rise", {62'd0, ifc.eng_start, busy}, 64'd3);
        repeat (7) cyc();
        chk("lat_pre_commit_board", board, BLINK_A);
        chk("lat_pre_commit_flags", {62'd0, ifc.eng_start, busy}, 64'd1);
        cyc();
        chk("lat_commit_board", board, BLINK_B);
        chk("lat_commit_busy", {63'd0, busy}, 64'd0);

        // Randomized steps against the reference rule.
        for (int t = 0; t < 20; t++) begin
            logic [63:0] mb;
            logic [15:0] mg;
            logic        ms, me;
            int          ns;
            mb = {$urandom(), $urandom()};
            if (t % 5 == 0) mb = mb & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            eng_lat = $urandom_range(1, 12);
            ns = $urandom_range(1, 4);
            do_load(mb);
            mg = 16'd0;
            for (int s = 0; s < ns; s++) begin
                logic [63:0] nb;
                do_step(1'($urandom_range(0, 1)));
                nb = life(mb);
                ms = (nb == mb);
                me = (nb == 64'd0);
                mb = nb;
                mg = mg + 16'd1;
                $display("rand %0d.%0d: lat=%0d board=%h gen=%0d", t, s, eng_lat, board, gen_count);
                chk("rand_board", board, mb);
                chk("rand_gen", {48'd0, gen_count}, {48'd0, mg});
                chk("rand_flags", {62'd0, stable, extinct}, {62'd0, ms, me});
            end
        end

        // Still life halts free-run.
        eng_lat = 4;
        do_load(BLOCK);
        do_step(1'b0);
        chk("still_stable", {63'd0, stable}, 64'd1);
        begin
            int rises;
            logic prev;
            rises = 0;
            prev = ifc.eng_start;
            run = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                cyc();
                if (ifc.eng_start && !prev) rises++;
                prev = ifc.eng_start;
            end
            run = 1'b0;
            chk("still_no_start", 64'(rises), 64'd0);
            chk("still_gen", {48'd0, gen_count}, 64'd1);
        end

        // Free-run blinker at TICK_DIV = 100.
        do_load(BLINK_A);
        begin
            logic [15:0] prev_g;
            prev_g = gen_count;
            run = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                cyc();
                if (gen_count != prev_g) begin
                    chk("freerun_phase", board, gen_count[0] ? BLINK_B : BLINK_A);
                    prev_g = gen_count;
                end
            end
            run = 1'b0;
            wait_idle();
            $display("freerun: gen=%0d board=%h", gen_count, board);
            chk("freerun_gens", {63'd0, (gen_count == 16'd9 || gen_count == 16'd10)}, 64'd1);
            chk("freerun_final", board, gen_count[0] ? BLINK_B : BLINK_A);
        end

        // Watchdog with a dead engine.
        mode = 1;
        do_load(BLINK_A);
        begin
            int hi;
            step = 1'b1;
            cyc();
            step = 1'b0;
            hi = ifc.eng_start ? 1 : 0;
            for (int i = 0; i < 200 && ifc.eng_start; i++) begin
                cyc();
                if (ifc.eng_start) hi++;
            end
            $display("watchdog: eng_start high %0d cycles", hi);
            chk("wd_start_cycles", 64'(hi), 64'd21);
            chk("wd_err_busy", {62'd0, timeout_err, busy}, 64'd2);
            chk("wd_board", board, BLINK_A);
            chk("wd_gen", {48'd0, gen_count}, 64'd0);
            do_load(BLINK_A);
            chk("wd_load_clears", {63'd0, timeout_err}, 64'd0);
        end

        // Load in the same cycle as eng_done during a pass.
        mode = 2;
        do_load(BLINK_A);
        step = 1'b1;
        cyc();
        step = 1'b0;
        repeat (3) cyc();
        man_next = 64'hDEAD_BEEF_0000_1111;
        man_done = 1'b1;
        seed = 64'hFF;
        load = 1'b1;
        cyc();
        man_done = 1'b0;
        load = 1'b0;
        chk("ldmid_board", board, 64'hFF);
        chk("ldmid_start_busy", {62'd0, ifc.eng_start, busy}, 64'd0);
        repeat (3) cyc();
        chk("ldmid_no_commit_board", board, 64'hFF);
        chk("ldmid_no_commit_gen", {48'd0, gen_count}, 64'd0);

        // Asynchronous reset during WAIT_DONE, then a late eng_done.
        do_load(BLINK_A);
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outputs", {61'd0, busy, ifc.eng_start, stable}, 64'd0);
        chk("arst_board", board, 64'd0);
        cyc();
        rst_n = 1'b1;
        man_next = BLINK_B;
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
        repeat (2) cyc();
        chk("arst_late_done_busy", {63'd0, busy}, 64'd0);
        chk("arst_late_done_gen", {48'd0, gen_count}, 64'd0);
        chk("arst_late_done_board", board, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
